// File: rtl/fifo_read_ctrl.sv
// Drains a FIFO read port into a 3-entry in-order buffer and presents it as a
// valid/ready stream. Read issue depends only on registered state and empty.
module fifo_read_ctrl #(
  parameter int unsigned data_width = 8
) (
  input  logic                  r_clk,
  input  logic                  rrst_n,
  input  logic                  empty,
  input  logic [data_width-1:0] data_out,
  output logic                  r_en,
  output logic                  m_valid,
  output logic [data_width-1:0] m_data,
  input  logic                  m_ready,
  output logic [15:0]           rd_count,
  output logic                  busy
);

  logic [data_width-1:0] store [3];
  logic [1:0]            head;
  logic [1:0]            tail;
  logic [1:0]            occ;
  logic                  inflight;
  logic [2:0]            pending;
  logic                  push;
  logic                  pop;

  function automatic logic [1:0] next_idx(input logic [1:0] idx);
    return (idx == 2'd2) ? 2'd0 : idx + 2'd1;
  endfunction

  // Words already buffered plus the one in flight reserve buffer slots, so a
  // read is only issued when its data is guaranteed a free slot on arrival.
  assign pending  = {1'b0, occ} + {2'b00, inflight};
  assign r_en     = rrst_n && !empty && (pending < 3'd3);
  assign m_valid  = (occ != 2'd0);
  assign m_data   = m_valid ? store[head] : '0;
  assign busy     = m_valid || inflight;
  assign push     = inflight;
  assign pop      = m_valid && m_ready;

  always_ff @(posedge r_clk or negedge rrst_n) begin
    if (!rrst_n) begin
      head     <= '0;
      tail     <= '0;
      occ      <= '0;
      inflight <= 1'b0;
      rd_count <= '0;
    end else begin
      inflight <= r_en;
      if (push) tail <= next_idx(tail);
      if (pop) begin
        head     <= next_idx(head);
        rd_count <= rd_count + 16'd1;
      end
      case ({push, pop})
        2'b10:   occ <= occ + 2'd1;
        2'b01:   occ <= occ - 2'd1;
        default: occ <= occ;
      endcase
    end
  end

  // Data storage carries no reset; its contents are only observable via
  // m_data, which is gated by occupancy.
  always_ff @(posedge r_clk) begin
    if (push) store[tail] <= data_out;
  end

endmodule

// File: tb/tb_fifo_read_ctrl.sv
// Directed bench for fifo_read_ctrl: table-driven per-cycle vectors plus
// sequences against a small FIFO model with an in-order scoreboard.
module tb_fifo_read_ctrl;

  logic        r_clk;
  logic        rrst_n;
  logic        empty;
  logic [7:0]  data_out;
  logic        r_en;
  logic        m_valid;
  logic [7:0]  m_data;
  logic        m_ready;
  logic [15:0] rd_count;
  logic        busy;

  fifo_read_ctrl #(.data_width(8)) dut (
    .r_clk    (r_clk),
    .rrst_n   (rrst_n),
    .empty    (empty),
    .data_out (data_out),
    .r_en     (r_en),
    .m_valid  (m_valid),
    .m_data   (m_data),
    .m_ready  (m_ready),
    .rd_count (rd_count),
    .busy     (busy)
  );

  initial r_clk = 1'b0;
  always #5 r_clk = ~r_clk;

  // FIFO model: data_out is registered one cycle after r_en
  logic       use_model;
  logic       tbl_empty;
  logic [7:0] tbl_dout;
  logic [7:0] model_dout;
  logic [7:0] mem [256];
  int         wp;
  int         rp;

  assign empty    = use_model ? (wp == rp) : tbl_empty;
  assign data_out = use_model ? model_dout : tbl_dout;

  initial begin
    rp         = 0;
    model_dout = 8'h00;
  end

  always @(posedge r_clk) begin
    if (use_model && r_en) begin
      model_dout <= mem[rp % 256];
      rp         <= rp + 1;
    end
  end

  int n_chk;
  int n_fail;
  int exp_idx;
  bit chk_data;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_chk++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h (t=%0t)", name, act, exp, $time);
    end
  endtask

  task automatic push_words(input int n, input logic [7:0] base);
    for (int i = 0; i < n; i++) begin
      mem[wp % 256] = base + 8'(i);
      wp++;
    end
  endtask

  task automatic step(input logic rdy);
    @(negedge r_clk);
    m_ready = rdy;
    #1;
    if (chk_data) begin
      chk("no_underflow", {31'd0, r_en && empty}, 32'd0);
      chk("occ_bound", ((rp - exp_idx) <= 3) ? 32'd1 : 32'd0, 32'd1);
      if (m_valid && m_ready) begin
        chk("order", {24'd0, m_data}, {24'd0, mem[exp_idx % 256]});
        exp_idx++;
      end
    end
  endtask

  typedef struct {
    logic        empty;
    logic [7:0]  dout;
    logic        rdy;
    logic        ren;
    logic        mv;
    logic [7:0]  md;
    logic        bsy;
    logic [15:0] cnt;
  } vec_t;

  vec_t tbl [10];

  int  rp0;
  bit  saw_ffff;
  bit  drained;

  initial begin
    n_chk    = 0;
    n_fail   = 0;
    exp_idx  = 0;
    wp       = 0;
    chk_data = 1'b0;
    use_model = 1'b0;
    tbl_empty = 1'b0;
    tbl_dout  = 8'h00;
    m_ready   = 1'b1;
    rrst_n    = 1'b0;

    // empty stuck high with m_ready toggling, then a 3-word FIFO drained
    tbl[0] = '{1'b1, 8'h00, 1'b1, 1'b0, 1'b0, 8'h00, 1'b0, 16'd0};
    tbl[1] = '{1'b1, 8'h00, 1'b0, 1'b0, 1'b0, 8'h00, 1'b0, 16'd0};
    tbl[2] = '{1'b1, 8'h00, 1'b1, 1'b0, 1'b0, 8'h00, 1'b0, 16'd0};
    tbl[3] = '{1'b1, 8'h00, 1'b0, 1'b0, 1'b0, 8'h00, 1'b0, 16'd0};
    tbl[4] = '{1'b0, 8'h00, 1'b1, 1'b1, 1'b0, 8'h00, 1'b0, 16'd0};
    tbl[5] = '{1'b0, 8'h11, 1'b1, 1'b1, 1'b0, 8'h00, 1'b1, 16'd0};
    tbl[6] = '{1'b0, 8'h22, 1'b1, 1'b1, 1'b1, 8'h11, 1'b1, 16'd0};
    tbl[7] = '{1'b1, 8'h33, 1'b1, 1'b0, 1'b1, 8'h22, 1'b1, 16'd1};
    tbl[8] = '{1'b1, 8'h33, 1'b1, 1'b0, 1'b1, 8'h33, 1'b1, 16'd2};
    tbl[9] = '{1'b1, 8'h33, 1'b1, 1'b0, 1'b0, 8'h00, 1'b0, 16'd3};

    // reset state, with empty low to show reset gates r_en
    repeat (3) @(negedge r_clk);
    #1;
    chk("rst_r_en", {31'd0, r_en}, 32'd0);
    chk("rst_m_valid", {31'd0, m_valid}, 32'd0);
    chk("rst_m_data", {24'd0, m_data}, 32'd0);
    chk("rst_busy", {31'd0, busy}, 32'd0);
    chk("rst_rd_count", {16'd0, rd_count}, 32'd0);
    tbl_empty = 1'b1;
    @(negedge r_clk);
    rrst_n = 1'b1;

    for (int i = 0; i < 10; i++) begin
      @(negedge r_clk);
      tbl_empty = tbl[i].empty;
      tbl_dout  = tbl[i].dout;
      m_ready   = tbl[i].rdy;
      #1;
      chk($sformatf("v%0d_r_en", i), {31'd0, r_en}, {31'd0, tbl[i].ren});
      chk($sformatf("v%0d_m_valid", i), {31'd0, m_valid}, {31'd0, tbl[i].mv});
      chk($sformatf("v%0d_m_data", i), {24'd0, m_data}, {24'd0, tbl[i].md});
      chk($sformatf("v%0d_busy", i), {31'd0, busy}, {31'd0, tbl[i].bsy});
      chk($sformatf("v%0d_rd_count", i), {16'd0, rd_count}, {16'd0, tbl[i].cnt});
    end

    // backpressure: 5 words, m_ready low -> only 3 reads, head held
    chk_data  = 1'b1;
    rp0       = rp;
    m_ready   = 1'b0;
    use_model = 1'b1;
    push_words(5, 8'hA1);
    for (int i = 0; i < 8; i++) step(1'b0);
    chk("bp_reads", rp - rp0, 32'd3);
    chk("bp_m_valid", {31'd0, m_valid}, 32'd1);
    chk("bp_m_data", {24'd0, m_data}, 32'h0000_00A1);
    chk("bp_busy", {31'd0, busy}, 32'd1);
    chk("bp_r_en", {31'd0, r_en}, 32'd0);
    for (int i = 0; i < 12; i++) step(1'b1);
    chk("bp_all_out", exp_idx, 32'd5);
    chk("bp_rd_count", {16'd0, rd_count}, 32'd8);

    // 10-word stream with random backpressure, then drain
    push_words(10, 8'h40);
    for (int i = 0; i < 60; i++) step(1'($urandom_range(0, 1)));
    for (int i = 0; i < 15; i++) step(1'b1);
    chk("rand_all_out", exp_idx, wp);
    chk("rand_rd_count", {16'd0, rd_count}, 32'd18);
    chk("rand_idle", {31'd0, busy}, 32'd0);

    // full throughput: r_en and m_valid both high every cycle after fill
    push_words(8, 8'h60);
    for (int i = 1; i < 14; i++) begin
      step(1'b1);
      if (i >= 2 && i <= 7) begin
        chk($sformatf("tp%0d_r_en", i), {31'd0, r_en}, 32'd1);
        chk($sformatf("tp%0d_m_valid", i), {31'd0, m_valid}, 32'd1);
      end
    end
    chk("tp_all_out", exp_idx, wp);
    chk("tp_idle", {31'd0, busy}, 32'd0);

    // reset with occ=2 and one read in flight
    rp0 = rp;
    push_words(5, 8'h80);
    for (int i = 0; i < 3; i++) step(1'b0);
    chk("pre_rst_reads", rp - rp0, 32'd3);
    chk("pre_rst_r_en", {31'd0, r_en}, 32'd0);
    chk("pre_rst_m_data", {24'd0, m_data}, 32'h0000_0080);
    #2;
    rrst_n = 1'b0;
    #1;
    chk("mid_rst_m_valid", {31'd0, m_valid}, 32'd0);
    chk("mid_rst_rd_count", {16'd0, rd_count}, 32'd0);
    chk("mid_rst_busy", {31'd0, busy}, 32'd0);
    chk("mid_rst_r_en", {31'd0, r_en}, 32'd0);
    chk("mid_rst_m_data", {24'd0, m_data}, 32'd0);
    @(negedge r_clk);
    @(negedge r_clk);
    rrst_n  = 1'b1;
    exp_idx = rp;
    for (int i = 0; i < 10; i++) step(1'b1);
    chk("post_rst_all_out", exp_idx, wp);
    chk("post_rst_rd_count", {16'd0, rd_count}, 32'd2);

    // rd_count wrap: 65534 more transfers take it from 2 through FFFF to 0
    chk_data = 1'b0;
    saw_ffff = 1'b0;
    drained  = 1'b0;
    wp       = wp + 65534;
    m_ready  = 1'b1;
    for (int i = 0; i < 70000 && !drained; i++) begin
      @(negedge r_clk);
      #1;
      if (rd_count == 16'hFFFF) saw_ffff = 1'b1;
      if (rp == wp && !busy) drained = 1'b1;
    end
    chk("wrap_drained", {31'd0, drained}, 32'd1);
    chk("wrap_saw_ffff", {31'd0, saw_ffff}, 32'd1);
    chk("wrap_rd_count", {16'd0, rd_count}, 32'd0);

    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
    $finish;
  end

endmodule

// File: doc/fifo_read_ctrl.md
FIFO_READ_CTRL -- requirements
Module: fifo_read_ctrl

Interface
REQ-001 Parameter: data_width, default 8, width of FIFO read data and output stream data.
REQ-002 r_clk  input  1  read-domain clock; all state updates on posedge r_clk.
REQ-003 rrst_n  input  1  reset, asynchronous, active-low.
REQ-004 empty  input  1  FIFO empty flag, synchronous to r_clk.
REQ-005 data_out  input  data_width  FIFO read data, valid in the cycle after r_en was high.
REQ-006 r_en  output  1  FIFO read enable, one pop per cycle high.
REQ-007 m_valid  output  1  output stream word available.
REQ-008 m_data  output  data_width  output stream word.
REQ-009 m_ready  input  1  downstream accepts m_data when m_valid && m_ready.
REQ-010 rd_count  output  16  count of words accepted downstream.
REQ-011 busy  output  1  high when the buffer holds a word or a read is in flight.

Function
REQ-012 The block SHALL drain the FIFO read port into a 3-entry in-order output buffer and present it as a valid/ready stream.
REQ-013 r_en SHALL equal !empty && rrst_n && (occ + inflight < 3); occ = buffered words (0..3), inflight = registered copy of r_en.
REQ-014 r_en SHALL NOT depend combinationally on m_ready.
REQ-015 r_en SHALL never be high while empty is high (no underflow).
REQ-016 When inflight is 1 in a cycle, data_out in that cycle SHALL be written at the buffer tail on the next posedge.
REQ-017 m_valid SHALL be (occ != 0); m_data SHALL be the buffer head, held stable while m_valid && !m_ready.
REQ-018 On m_valid && m_ready the head SHALL be removed on the next posedge.
REQ-019 Simultaneous capture and removal in one cycle SHALL leave occ unchanged and preserve order.
REQ-020 Words SHALL leave m_data in exact FIFO pop order, none dropped or duplicated.
REQ-021 Latency: first word SHALL appear on m_valid two cycles after r_en rises (issue, capture, present).
REQ-022 With empty low and m_ready high continuously, r_en and m_valid SHALL stay high every cycle after fill (full throughput).
REQ-023 With m_ready low, r_en SHALL deassert once occ + inflight = 3; at most 3 words SHALL be held.
REQ-024 Buffer head/tail indices SHALL wrap modulo 3 (2 -> 0).
REQ-025 rd_count SHALL increment by 1 on each accepted transfer, wrapping 16'hFFFF -> 16'h0000.
REQ-026 busy SHALL equal (occ != 0) || inflight.

Reset
REQ-027 While rrst_n is low: r_en = 0, m_valid = 0, m_data = 0, rd_count = 0, busy = 0, occ = 0, inflight = 0.
REQ-028 Assertion of rrst_n mid-operation SHALL immediately discard buffered and in-flight words; data_out arriving after reset SHALL be ignored.
REQ-029 First r_en after deassertion SHALL occur no earlier than the first posedge r_clk with rrst_n high and empty low.
REQ-030 Outputs SHALL contain no X after reset for any input without X.

Verification
REQ-031 FIFO holds 0x11,0x22,0x33, m_ready=1 -> r_en high 3 cycles, m_data 0x11,0x22,0x33 on consecutive cycles from 2 cycles after first r_en, rd_count=3.
REQ-032 FIFO holds 5 words, m_ready=0 -> exactly 3 r_en pulses, m_data holds first word, busy=1; m_ready=1 -> remaining 2 popped, all 5 in order.
REQ-033 empty=1 throughout with m_ready toggling -> r_en never high, m_valid=0, rd_count=0.
REQ-034 Continuous stream of 10 words, m_ready random -> output order matches input, occ never >3, head/tail wrap exercised.
REQ-035 rrst_n pulsed low with occ=2, inflight=1 -> m_valid=0 and rd_count=0 immediately; stale data_out not emitted after release.
REQ-036 Preload rd_count path with 65536 transfers -> rd_count wraps 0xFFFF -> 0x0000.
